img_sram_responder: RTL and testbench

- Slave-side responder for img_sram_intf. It holds one image plane (ROWS x COLS bytes) and serves conv_row_controller-style masters with a fixed 1-cycle read latency.
- A host stream port preloads the image before a convolution pass (load) and drains the result afterwards (dump), in raster order, using valid/ready handshakes.
- One instance backs the source image; a second instance backs the row/transpose buffer.

---
 rtl/img_sram_responder_if.sv | 13 +
 rtl/img_sram_responder.sv | 176 +++++++++++++++++
 tb/tb_img_sram_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/img_sram_responder_if.sv
// Byte-wide image SRAM bus. The master drives address/data/strobes;
// the responder returns read data one cycle after the address.
interface img_sram_intf;
    logic       write_en;
    logic       sense_en;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] din;
    logic [7:0] dout;

    modport slv (input write_en, sense_en, row, col, din, output dout);
    modport mst (output write_en, sense_en, row, col, din, input dout);
endinterface

// File: rtl/img_sram_responder.sv
// Image-plane SRAM responder: 1-cycle-latency img_sram_intf slave in IDLE,
// plus a host stream port that loads/dumps a raster window of the plane.
module img_sram_responder #(
    parameter int ROWS = 64,
    parameter int COLS = 64
) (
    input  logic       clk,
    input  logic       rst,
    img_sram_intf.slv  sram,
    input  logic       host_start,
    input  logic       host_mode,
    input  logic [7:0] nrows,
    input  logic [7:0] ncols,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       busy,
    output logic       oob_err,
    output logic       coll_err
);

    localparam int         RIW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int         CIW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [8:0] ROWS9 = 9'(ROWS);
    localparam logic [8:0] COLS9 = 9'(COLS);

    typedef enum logic [1:0] {IDLE, LOAD, DUMP_RD, DUMP_OUT} state_t;

    state_t     state;
    logic [7:0] r, c;
    logic [7:0] r_last, c_last;
    logic [7:0] r_nxt, c_nxt;

    logic [7:0] mem [ROWS][COLS];

    logic           if_in_range;
    logic           load_beat;
    logic           at_last;
    logic           start_ok;
    logic [8:0]     nrows_clamp, ncols_clamp;
    logic           wr_en;
    logic [RIW-1:0] wr_row;
    logic [CIW-1:0] wr_col;
    logic [7:0]     wr_data;

    assign if_in_range = ({1'b0, sram.row} < ROWS9) && ({1'b0, sram.col} < COLS9);
    assign load_beat   = (state == LOAD) && s_valid && s_ready;
    assign at_last     = (r == r_last) && (c == c_last);
    assign start_ok    = host_start && (nrows != 8'd0) && (ncols != 8'd0);
    assign nrows_clamp = ({1'b0, nrows} > ROWS9) ? ROWS9 : {1'b0, nrows};
    assign ncols_clamp = ({1'b0, ncols} > COLS9) ? COLS9 : {1'b0, ncols};

    // Raster advance: wrap is by comparison, so 8-bit counters cover 256x256.
    assign c_nxt = (c == c_last) ? 8'd0 : c + 8'd1;
    assign r_nxt = (c == c_last) ? r + 8'd1 : r;

    // Single write port shared by the host load stream and the idle bus.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        wr_en   = 1'b0;
        wr_row  = sram.row[RIW-1:0];
        wr_col  = sram.col[CIW-1:0];
        wr_data = sram.din;
        if (!rst) begin
            if (load_beat) begin
                wr_en   = 1'b1;
                wr_row  = r[RIW-1:0];
                wr_col  = c[CIW-1:0];
                wr_data = s_data;
            end else if ((state == IDLE) && sram.write_en && if_in_range) begin
                wr_en = 1'b1;
            end
        end
    end

    // NOTE: the array is deliberately not reset; a reset loop over a RAM would prevent block-RAM mapping.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Bus side: serves reads/writes only while idle; flags misuse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram.dout <= 8'h00;
            oob_err   <= 1'b0;
            coll_err  <= 1'b0;
        end else if (state == IDLE) begin
            if (!if_in_range) begin
                oob_err <= 1'b1;
            end
            if (sram.write_en) begin
                if (sram.sense_en) begin
                    sram.dout <= sram.din;
                end
            end else begin
                sram.dout <= if_in_range ? mem[sram.row[RIW-1:0]][sram.col[CIW-1:0]] : 8'h00;
            end
        end else if (sram.write_en || sram.sense_en) begin
            coll_err <= 1'b1;
        end
    end

    // Host transfer sequencer; all stream outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r       <= 8'd0;
            c       <= 8'd0;
            r_last  <= 8'd0;
            c_last  <= 8'd0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= 8'h00;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        r      <= 8'd0;
                        c      <= 8'd0;
                        r_last <= 8'(nrows_clamp - 9'd1);
                        c_last <= 8'(ncols_clamp - 9'd1);
                        busy   <= 1'b1;
                        if (host_mode) begin
                            state <= DUMP_RD;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_beat) begin
                        if (at_last) begin
                            state   <= IDLE;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            r <= r_nxt;
                            c <= c_nxt;
                        end
                    end
                end
                DUMP_RD: begin
                    m_data  <= mem[r[RIW-1:0]][c[CIW-1:0]];
                    m_last  <= at_last;
                    m_valid <= 1'b1;
                    state   <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (at_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            r     <= r_nxt;
                            c     <= c_nxt;
                            state <= DUMP_RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_sram_responder.sv
// Directed bench for img_sram_responder: host load/dump, bus timing,
// out-of-range and collision flags, and reset abort.
module tb_img_sram_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_start, host_mode;
    logic [7:0] nrows, ncols;
    logic       s_valid, s_ready;
    logic [7:0] s_data;
    logic       m_valid, m_ready, m_last;
    logic [7:0] m_data;
    logic       busy, oob_err, coll_err;

    int total  = 0;
    int passed = 0;

    img_sram_intf sram_if ();

    img_sram_responder #(.ROWS(64), .COLS(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .sram       (sram_if),
        .host_start (host_start),
        .host_mode  (host_mode),
        .nrows      (nrows),
        .ncols      (ncols),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .oob_err    (oob_err),
        .coll_err   (coll_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_cycle(input logic we, input logic se, input logic [7:0] row,
                             input logic [7:0] col, input logic [7:0] din);
        sram_if.write_en = we;
        sram_if.sense_en = se;
        sram_if.row      = row;
        sram_if.col      = col;
        sram_if.din      = din;
        tick();
        sram_if.write_en = 1'b0;
        sram_if.sense_en = 1'b0;
    endtask

    task automatic host_go(input logic mode, input logic [7:0] nr, input logic [7:0] nc);
        host_start = 1'b1;
        host_mode  = mode;
        nrows      = nr;
        ncols      = nc;
        tick();
        host_start = 1'b0;
    endtask

    initial begin
        int idx, cyc, last_cyc, stall, accepted;

        rst = 1'b1;
        host_start = 1'b0; host_mode = 1'b0; nrows = 8'd0; ncols = 8'd0;
        s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        sram_if.write_en = 1'b0; sram_if.sense_en = 1'b0;
        sram_if.row = 8'd0; sram_if.col = 8'd0; sram_if.din = 8'h00;

        // Reset state
        tick(); tick();
        check("rst_dout",     32'(sram_if.dout), 32'h0);
        check("rst_m_data",   32'(m_data),   32'h0);
        check("rst_s_ready",  32'(s_ready),  32'h0);
        check("rst_m_valid",  32'(m_valid),  32'h0);
        check("rst_m_last",   32'(m_last),   32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_oob_err",  32'(oob_err),  32'h0);
        check("rst_coll_err", 32'(coll_err), 32'h0);
        rst = 1'b0;
        tick();

        // Load 4x6 ramp with s_valid held high
        host_go(1'b0, 8'd4, 8'd6);
        check("load_s_ready_on", 32'(s_ready), 32'h1);
        check("load_busy_on",    32'(busy),    32'h1);
        accepted = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            s_data = 8'(i);
            if (s_ready) accepted++;
            tick();
        end
        s_valid = 1'b0;
        check("load_beats",       32'(accepted), 32'd24);
        check("load_busy_off",    32'(busy),     32'h0);
        check("load_s_ready_off", 32'(s_ready),  32'h0);

        bus_cycle(1'b0, 1'b0, 8'd2, 8'd3, 8'h00);
        check("read_2_3", 32'(sram_if.dout), 32'd15);

        // Dump 4x6 with m_ready held high
        host_go(1'b1, 8'd4, 8'd6);
        check("dump1_busy_on", 32'(busy), 32'h1);
        m_ready = 1'b1;
        idx = 0; cyc = 0; last_cyc = 0;
        while (idx < 24 && cyc < 200) begin
            if (m_valid) begin
                check("dump1_data", 32'(m_data), 32'(idx));
                check("dump1_last", 32'(m_last), 32'(idx == 23));
                if (idx > 0) check("dump1_gap", 32'(cyc - last_cyc), 32'd2);
                last_cyc = cyc;
                idx++;
            end
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        check("dump1_count",    32'(idx),     32'd24);
        check("dump1_busy_off", 32'(busy),    32'h0);
        check("dump1_valid_off", 32'(m_valid), 32'h0);

        // Dump again with m_ready toggling and a 5-cycle stall on beat 7
        host_go(1'b1, 8'd4, 8'd6);
        idx = 0; cyc = 0; stall = 0;
        while (idx < 24 && cyc < 400) begin
            if (m_valid) begin
                check("dump2_data", 32'(m_data), 32'(idx));
                check("dump2_last", 32'(m_last), 32'(idx == 23));
            end
            if (m_valid && idx == 7 && stall < 5) begin
                m_ready = 1'b0;
                stall++;
            end else begin
                m_ready = cyc[0];
            end
            if (m_valid && m_ready) idx++;
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        check("dump2_count",    32'(idx),   32'd24);
        check("dump2_stall",    32'(stall), 32'd5);
        check("dump2_busy_off", 32'(busy),  32'h0);

        // Bus write-through, read-after-write, write without sense
        bus_cycle(1'b1, 1'b1, 8'd1, 8'd1, 8'hAA);
        check("wr_through", 32'(sram_if.dout), 32'hAA);
        bus_cycle(1'b0, 1'b1, 8'd1, 8'd1, 8'h00);
        check("rd_1_1", 32'(sram_if.dout), 32'hAA);
        bus_cycle(1'b1, 1'b0, 8'd1, 8'd2, 8'h11);
        check("wr_no_sense_hold", 32'(sram_if.dout), 32'hAA);
        bus_cycle(1'b0, 1'b0, 8'd1, 8'd2, 8'h00);
        check("rd_1_2", 32'(sram_if.dout), 32'h11);
        check("oob_clear", 32'(oob_err), 32'h0);

        // Out-of-range write/read; (6,2) is the 6-bit alias of (70,2)
        bus_cycle(1'b1, 1'b0, 8'd6, 8'd2, 8'h66);
        bus_cycle(1'b1, 1'b0, 8'd70, 8'd2, 8'h55);
        check("oob_set",       32'(oob_err),      32'h1);
        check("oob_wr_hold",   32'(sram_if.dout), 32'h11);
        bus_cycle(1'b0, 1'b0, 8'd70, 8'd2, 8'h00);
        check("oob_rd_zero",   32'(sram_if.dout), 32'h0);
        bus_cycle(1'b0, 1'b0, 8'd6, 8'd2, 8'h00);
        check("oob_no_alias",  32'(sram_if.dout), 32'h66);
        sram_if.row = 8'd0; sram_if.col = 8'd0;
        tick(); tick(); tick();
        check("oob_sticky",    32'(oob_err),  32'h1);
        check("coll_clear",    32'(coll_err), 32'h0);

        // Zero-size start is ignored
        host_go(1'b0, 8'd0, 8'd5);
        check("zero_start_idle", 32'(busy), 32'h0);

        // 8x8 load aborted by reset after 10 beats, with a colliding bus write
        host_go(1'b0, 8'd8, 8'd8);
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = 8'(8'h80 + i);
            sram_if.write_en = (i == 3);
            sram_if.din      = 8'hEE;
            tick();
        end
        sram_if.write_en = 1'b0;
        check("abort_coll_set", 32'(coll_err), 32'h1);
        check("abort_busy_pre", 32'(busy),     32'h1);
        rst = 1'b1;
        s_data = 8'h8A;
        tick();
        check("abort_busy",     32'(busy),         32'h0);
        check("abort_s_ready",  32'(s_ready),      32'h0);
        check("abort_coll_clr", 32'(coll_err),     32'h0);
        check("abort_oob_clr",  32'(oob_err),      32'h0);
        check("abort_dout",     32'(sram_if.dout), 32'h0);
        rst = 1'b0;
        s_valid = 1'b0;
        tick();

        bus_cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'h00);
        check("abort_keep_0_0", 32'(sram_if.dout), 32'h80);
        bus_cycle(1'b0, 1'b0, 8'd1, 8'd1, 8'h00);
        check("abort_keep_1_1", 32'(sram_if.dout), 32'h89);
        bus_cycle(1'b0, 1'b0, 8'd1, 8'd2, 8'h00);
        check("abort_stop_1_2", 32'(sram_if.dout), 32'h11);
        sram_if.row = 8'd0; sram_if.col = 8'd0;

        // 1x1 load then 1x1 dump
        host_go(1'b0, 8'd1, 8'd1);
        check("one_s_ready", 32'(s_ready), 32'h1);
        s_valid = 1'b1;
        s_data  = 8'h33;
        tick();
        s_valid = 1'b0;
        check("one_load_done", 32'(busy), 32'h0);
        host_go(1'b1, 8'd1, 8'd1);
        tick();
        check("one_m_valid", 32'(m_valid), 32'h1);
        check("one_m_data",  32'(m_data),  32'h33);
        check("one_m_last",  32'(m_last),  32'h1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("one_dump_done",  32'(busy),    32'h0);
        check("one_valid_off",  32'(m_valid), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
